// File: rtl/pipe_stall_ctrl.sv
// pipe_stall_ctrl: turns hazard-unit stall/flush requests into pipeline register enables/flushes.
// Optional build macro PIPE_STALL_PERF_CNT_EN adds saturating stall and branch-flush counters.
`default_nettype none

module pipe_stall_ctrl #(
    parameter int FLUSH_CYCLES = 1,
    parameter int STALL_MAX    = 64,
    parameter int CNT_W        = 16
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [7:0]       i_stall_vec,
    input  logic             i_dmem_ready,
    output logic             o_pc_en,
    output logic             o_ifid_en,
    output logic             o_ifid_flush,
    output logic             o_idex_en,
    output logic             o_idex_flush,
    output logic             o_exmem_en,
    output logic             o_exmem_flush,
    output logic             o_memwb_en,
    output logic             o_memwb_flush,
    output logic             o_busy,
    output logic             o_stall_err,
    output logic [CNT_W-1:0] o_stall_cnt,
    output logic [CNT_W-1:0] o_flush_cnt
);

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_FREEZE = 2'd1,
        ST_FLUSH  = 2'd2
    } state_t;

    localparam logic [2:0] C_FLUSH_FULL   = 3'(FLUSH_CYCLES);
    localparam logic [2:0] C_FLUSH_RELOAD = 3'(FLUSH_CYCLES - 1);
    localparam logic [7:0] C_STALL_MAX    = 8'(STALL_MAX);
    localparam bit         C_MULTI_FLUSH  = (FLUSH_CYCLES > 1);

    state_t     r_state;
    logic [2:0] r_flush_cnt;
    logic       r_pending;
    logic [7:0] r_wd_cnt;
    logic       r_stall_err;

    logic w_branch_req;
    logic w_freeze;
    logic w_pc_en, w_ifid_en, w_ifid_flush, w_idex_en, w_idex_flush;
    logic w_exmem_en, w_exmem_flush, w_memwb_en, w_memwb_flush;

    // Returns {en, flush}; the reserved code 10 is treated as a flush.
    function automatic logic [1:0] decode_stage(input logic [1:0] code);
        case (code)
            2'b00:   return 2'b10;
            2'b01:   return 2'b00;
            default: return 2'b11;
        endcase
    endfunction

    assign w_branch_req = ~i_stall_vec[7] & (i_stall_vec[6:5] == 2'b11);
    assign w_freeze     = ~i_dmem_ready;

    always_comb begin
        w_pc_en                      = ~i_stall_vec[7];
        {w_ifid_en,  w_ifid_flush}   = decode_stage(i_stall_vec[6:5]);
        {w_idex_en,  w_idex_flush}   = decode_stage(i_stall_vec[4:3]);
        {w_exmem_en, w_exmem_flush}  = decode_stage(i_stall_vec[2:1]);
        w_memwb_en                   = 1'b1;
        w_memwb_flush                = i_stall_vec[0];

        if (i_rst) begin
            w_pc_en       = 1'b1;
            w_ifid_en     = 1'b1;
            w_ifid_flush  = 1'b0;
            w_idex_en     = 1'b1;
            w_idex_flush  = 1'b0;
            w_exmem_en    = 1'b1;
            w_exmem_flush = 1'b0;
            w_memwb_en    = 1'b1;
            w_memwb_flush = 1'b0;
        end else if (w_freeze) begin
            w_pc_en       = 1'b0;
            w_ifid_en     = 1'b0;
            w_ifid_flush  = 1'b0;
            w_idex_en     = 1'b0;
            w_idex_flush  = 1'b0;
            w_exmem_en    = 1'b0;
            w_exmem_flush = 1'b0;
            w_memwb_en    = 1'b0;
            w_memwb_flush = 1'b0;
        end else if (r_state == ST_FLUSH) begin
            // Only the front end is forced; downstream stages still obey the hazard unit.
            w_pc_en      = 1'b1;
            w_ifid_en    = 1'b1;
            w_ifid_flush = 1'b1;
        end
    end

    assign o_pc_en       = w_pc_en;
    assign o_ifid_en     = w_ifid_en;
    assign o_ifid_flush  = w_ifid_flush;
    assign o_idex_en     = w_idex_en;
    assign o_idex_flush  = w_idex_flush;
    assign o_exmem_en    = w_exmem_en;
    assign o_exmem_flush = w_exmem_flush;
    assign o_memwb_en    = w_memwb_en;
    assign o_memwb_flush = w_memwb_flush;
    assign o_stall_err   = r_stall_err;

    assign o_busy = ~i_rst & ((r_state != ST_RUN)
                    | ~(w_pc_en & w_ifid_en & w_idex_en & w_exmem_en & w_memwb_en)
                    | w_ifid_flush | w_idex_flush | w_exmem_flush | w_memwb_flush);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state     <= ST_RUN;
            r_flush_cnt <= 3'd0;
            r_pending   <= 1'b0;
        end else begin
            case (r_state)
                ST_RUN: begin
                    if (w_freeze) begin
                        r_state <= ST_FREEZE;
                        if (w_branch_req) r_pending <= 1'b1;
                    end else if (w_branch_req && C_MULTI_FLUSH) begin
                        r_state     <= ST_FLUSH;
                        r_flush_cnt <= C_FLUSH_RELOAD;
                    end
                end
                ST_FREEZE: begin
                    if (w_freeze) begin
                        if (w_branch_req) r_pending <= 1'b1;
                    end else if (r_pending) begin
                        // The deferred branch gets its full flush window after the freeze.
                        r_state     <= ST_FLUSH;
                        r_flush_cnt <= C_FLUSH_FULL;
                        r_pending   <= 1'b0;
                    end else if (w_branch_req && C_MULTI_FLUSH) begin
                        r_state     <= ST_FLUSH;
                        r_flush_cnt <= C_FLUSH_RELOAD;
                    end else begin
                        r_state <= ST_RUN;
                    end
                end
                ST_FLUSH: begin
                    if (w_freeze) begin
                        r_state   <= ST_FREEZE;
                        r_pending <= 1'b1;
                    end else if (w_branch_req) begin
                        if (C_MULTI_FLUSH) r_flush_cnt <= C_FLUSH_RELOAD;
                        else               r_state     <= ST_RUN;
                    end else if (r_flush_cnt <= 3'd1) begin
                        r_state <= ST_RUN;
                    end else begin
                        r_flush_cnt <= r_flush_cnt - 3'd1;
                    end
                end
                default: r_state <= ST_RUN;
            endcase
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wd_cnt    <= 8'd0;
            r_stall_err <= 1'b0;
        end else if (!w_pc_en) begin
            if (r_wd_cnt != C_STALL_MAX) r_wd_cnt <= r_wd_cnt + 8'd1;
            if (r_wd_cnt >= C_STALL_MAX - 8'd1) r_stall_err <= 1'b1;
        end else begin
            r_wd_cnt <= 8'd0;
        end
    end

`ifdef PIPE_STALL_PERF_CNT_EN
    logic             w_accept;
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_flush_evt_cnt;

    // A release from freeze counts once even if a fresh request arrives on the same cycle.
    assign w_accept = ~w_freeze & (w_branch_req | ((r_state == ST_FREEZE) & r_pending));

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_stall_cnt     <= '0;
            r_flush_evt_cnt <= '0;
        end else begin
            if (!w_pc_en && !(&r_stall_cnt))
                r_stall_cnt <= r_stall_cnt + 1'b1;
            if (w_accept && !(&r_flush_evt_cnt))
                r_flush_evt_cnt <= r_flush_evt_cnt + 1'b1;
        end
    end

    assign o_stall_cnt = r_stall_cnt;
    assign o_flush_cnt = r_flush_evt_cnt;
`else
    assign o_stall_cnt = '0;
    assign o_flush_cnt = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_pipe_stall_ctrl.sv
// tb_pipe_stall_ctrl: table-driven decode vectors plus hand-written branch, freeze, watchdog and reset sequences.
`default_nettype none

module tb_pipe_stall_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  vec;
    logic        ready;
    logic        pc_en, ifid_en, ifid_flush, idex_en, idex_flush;
    logic        exmem_en, exmem_flush, memwb_en, memwb_flush;
    logic        busy, stall_err;
    logic [15:0] stall_cnt, flush_cnt;
    logic [8:0]  outs;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    pipe_stall_ctrl #(
        .FLUSH_CYCLES(3),
        .STALL_MAX   (4),
        .CNT_W       (16)
    ) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_stall_vec  (vec),
        .i_dmem_ready (ready),
        .o_pc_en      (pc_en),
        .o_ifid_en    (ifid_en),
        .o_ifid_flush (ifid_flush),
        .o_idex_en    (idex_en),
        .o_idex_flush (idex_flush),
        .o_exmem_en   (exmem_en),
        .o_exmem_flush(exmem_flush),
        .o_memwb_en   (memwb_en),
        .o_memwb_flush(memwb_flush),
        .o_busy       (busy),
        .o_stall_err  (stall_err),
        .o_stall_cnt  (stall_cnt),
        .o_flush_cnt  (flush_cnt)
    );

    // {pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, exmem_flush, memwb_en, memwb_flush}
    assign outs = {pc_en, ifid_en, ifid_flush, idex_en, idex_flush,
                   exmem_en, exmem_flush, memwb_en, memwb_flush};

    typedef struct packed {
        logic [7:0] vec;
        logic [8:0] exp;
        logic       busy;
    } vec_t;

    vec_t tbl [11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic [7:0] v, input logic r);
        vec   = v;
        ready = r;
        #2;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst   = 1'b1;
        vec   = 8'h00;
        ready = 1'b1;
        tick();
        tick();
        #3;
        rst = 1'b0;
        #1;
    endtask

    initial begin
        tbl[0]  = '{vec: 8'h00, exp: 9'b110101010, busy: 1'b0};
        tbl[1]  = '{vec: 8'hB8, exp: 9'b000111010, busy: 1'b1};
        tbl[2]  = '{vec: 8'h00, exp: 9'b110101010, busy: 1'b0};
        tbl[3]  = '{vec: 8'h40, exp: 9'b111101010, busy: 1'b1};
        tbl[4]  = '{vec: 8'h01, exp: 9'b110101011, busy: 1'b1};
        tbl[5]  = '{vec: 8'h80, exp: 9'b010101010, busy: 1'b1};
        tbl[6]  = '{vec: 8'h00, exp: 9'b110101010, busy: 1'b0};
        tbl[7]  = '{vec: 8'h14, exp: 9'b110111110, busy: 1'b1};
        tbl[8]  = '{vec: 8'h0A, exp: 9'b110000010, busy: 1'b1};
        tbl[9]  = '{vec: 8'hE0, exp: 9'b011101010, busy: 1'b1};
        tbl[10] = '{vec: 8'h00, exp: 9'b110101010, busy: 1'b0};

        rst   = 1'b1;
        vec   = 8'h00;
        ready = 1'b1;
        #3;
        chk("reset_outs", 32'(outs), 32'(9'b110101010));
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_err", 32'(stall_err), 32'd0);
        chk("reset_stall_cnt", 32'(stall_cnt), 32'd0);
        chk("reset_flush_cnt", 32'(flush_cnt), 32'd0);
        do_reset();

        for (int i = 0; i < 11; i++) begin
            drive(tbl[i].vec, 1'b1);
            chk($sformatf("tbl%0d_outs", i), 32'(outs), 32'(tbl[i].exp));
            chk($sformatf("tbl%0d_busy", i), 32'(busy), 32'(tbl[i].busy));
            tick();
        end
        chk("tbl_err", 32'(stall_err), 32'd0);

        // Branch with a three-cycle IF/ID flush.
        do_reset();
        drive(8'h60, 1'b1);
        chk("br0_flush", 32'(ifid_flush), 32'd1);
        chk("br0_ifid_en", 32'(ifid_en), 32'd1);
        chk("br0_pc_en", 32'(pc_en), 32'd1);
        tick();
        for (int k = 1; k < 3; k++) begin
            drive(8'h00, 1'b1);
            chk($sformatf("br%0d_flush", k), 32'(ifid_flush), 32'd1);
            chk($sformatf("br%0d_busy", k), 32'(busy), 32'd1);
            tick();
        end
        drive(8'h00, 1'b1);
        chk("br3_flush", 32'(ifid_flush), 32'd0);
        chk("br3_busy", 32'(busy), 32'd0);
`ifdef PIPE_STALL_PERF_CNT_EN
        chk("br_flush_cnt", 32'(flush_cnt), 32'd1);
`endif
        tick();

        // Freeze with a branch deferred until memory is ready.
        do_reset();
        for (int k = 0; k < 4; k++) begin
            drive((k == 1) ? 8'h60 : 8'h00, 1'b0);
            chk($sformatf("frz%0d_outs", k), 32'(outs), 32'd0);
            chk($sformatf("frz%0d_busy", k), 32'(busy), 32'd1);
            tick();
        end
        chk("frz_wd_err", 32'(stall_err), 32'd1);
        drive(8'h00, 1'b1);
        chk("frz_rel_busy", 32'(busy), 32'd1);
        chk("frz_rel_pc_en", 32'(pc_en), 32'd1);
        tick();
        for (int k = 0; k < 3; k++) begin
            drive(8'h00, 1'b1);
            chk($sformatf("frz_fl%0d_flush", k), 32'(ifid_flush), 32'd1);
            chk($sformatf("frz_fl%0d_en", k), 32'(ifid_en), 32'd1);
            tick();
        end
        drive(8'h00, 1'b1);
        chk("frz_end_flush", 32'(ifid_flush), 32'd0);
        chk("frz_end_busy", 32'(busy), 32'd0);
        chk("frz_err_sticky", 32'(stall_err), 32'd1);
`ifdef PIPE_STALL_PERF_CNT_EN
        chk("frz_flush_cnt", 32'(flush_cnt), 32'd1);
        chk("frz_stall_cnt", 32'(stall_cnt), 32'd4);
`else
        chk("frz_flush_cnt_off", 32'(flush_cnt), 32'd0);
        chk("frz_stall_cnt_off", 32'(stall_cnt), 32'd0);
`endif
        tick();

        // Watchdog trips on the fourth consecutive stalled edge.
        do_reset();
        for (int k = 0; k < 4; k++) begin
            drive(8'hAB, 1'b1);
            chk($sformatf("wd%0d_err", k), 32'(stall_err), 32'd0);
            chk($sformatf("wd%0d_outs", k), 32'(outs), 32'(9'b000000011));
            tick();
        end
        chk("wd_err_set", 32'(stall_err), 32'd1);
        drive(8'h00, 1'b1);
        chk("wd_err_hold0", 32'(stall_err), 32'd1);
        tick();
        chk("wd_err_hold1", 32'(stall_err), 32'd1);

        // Asynchronous reset pulse in the middle of a freeze.
        do_reset();
        drive(8'h00, 1'b0);
        tick();
        drive(8'h00, 1'b0);
        tick();
        #3;
        rst = 1'b1;
        #1;
        chk("arst_outs", 32'(outs), 32'(9'b110101010));
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_err", 32'(stall_err), 32'd0);
        rst   = 1'b0;
        ready = 1'b1;
        vec   = 8'h00;
        #1;
        chk("arst_state_run", 32'(busy), 32'd0);
        chk("arst_outs_after", 32'(outs), 32'(9'b110101010));
        tick();
        chk("arst_busy_next", 32'(busy), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
